// File: rtl/sie_phase_sequencer_if.sv
// rtl/sie_phase_sequencer_if.sv - SIE sequencer request, duration and status bundle
interface sie_phase_sequencer_if #(
  parameter int WIDTH = 18
);
  logic                    ignite_req;
  logic                    abort;
  logic [15:0]             sie_phase2_dur;
  logic [15:0]             sie_phase3_dur;
  logic [15:0]             sie_phase4_dur;
  logic [15:0]             sie_phase5_dur;
  logic [15:0]             sie_phase6_dur;
  logic [15:0]             sie_refractory;
  logic [2:0]              phase;
  logic [15:0]             phase_timer;
  logic                    sie_active;
  logic                    ignite_ack;
  logic                    event_done;
  logic [7:0]              event_count;
  logic signed [WIDTH-1:0] envelope;

  modport master (
    output ignite_req, abort,
    output sie_phase2_dur, sie_phase3_dur, sie_phase4_dur,
    output sie_phase5_dur, sie_phase6_dur, sie_refractory,
    input  phase, phase_timer, sie_active, ignite_ack, event_done,
    input  event_count, envelope
  );

  modport slave (
    input  ignite_req, abort,
    input  sie_phase2_dur, sie_phase3_dur, sie_phase4_dur,
    input  sie_phase5_dur, sie_phase6_dur, sie_refractory,
    output phase, phase_timer, sie_active, ignite_ack, event_done,
    output event_count, envelope
  );
endinterface

// File: rtl/sie_phase_sequencer.sv
// rtl/sie_phase_sequencer.sv - SIE event phase sequencer on the 4 kHz tick
// Optional Q14 envelope generator enabled by SIE_ENVELOPE_EN.
module sie_phase_sequencer #(
  parameter int WIDTH    = 18,
  parameter int FRAC     = 14,
  parameter int ENV_STEP = 2
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  clk_en,
  sie_phase_sequencer_if.slave sie
);

  // Encoding matches the reported phase, so P6 + 1 lands on REFR.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_P4   = 3'd4,
    S_P5   = 3'd5,
    S_P6   = 3'd6,
    S_REFR = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     timer_q, timer_d;
  logic [5:0][15:0] dur_q;
  logic [15:0]     cur_dur, last_tick;
  logic            ack_q, ack_d, done_q, done_d, active_q;
  logic [7:0]      count_q, count_d;
  logic            load;

  always_comb begin
    cur_dur = '0;
    case (state_q)
      S_P2:    cur_dur = dur_q[0];
      S_P3:    cur_dur = dur_q[1];
      S_P4:    cur_dur = dur_q[2];
      S_P5:    cur_dur = dur_q[3];
      S_P6:    cur_dur = dur_q[4];
      S_REFR:  cur_dur = dur_q[5];
      default: cur_dur = '0;
    endcase
    last_tick = (cur_dur == '0) ? '0 : cur_dur - 16'd1;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    count_d = count_q;
    load    = 1'b0;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (sie.ignite_req && !sie.abort) begin
            state_d = S_P2;
            timer_d = '0;
            ack_d   = 1'b1;
            count_d = count_q + 8'd1;
            load    = 1'b1;
          end
        end
        S_P2, S_P3, S_P4, S_P5, S_P6: begin
          if (sie.abort) begin
            state_d = S_REFR;
            timer_d = '0;
          end else if (timer_q == last_tick) begin
            state_d = state_t'(state_q + 3'd1);
            timer_d = '0;
            done_d  = (state_q == S_P6);
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        S_REFR: begin
          if (timer_q == last_tick) begin
            state_d = S_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      dur_q    <= '0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      count_q  <= count_d;
      active_q <= (state_d inside {S_P2, S_P3, S_P4, S_P5, S_P6});
      if (load) begin
        dur_q <= {sie.sie_refractory, sie.sie_phase6_dur, sie.sie_phase5_dur,
                  sie.sie_phase4_dur, sie.sie_phase3_dur, sie.sie_phase2_dur};
      end
    end
  end

  assign sie.phase       = state_q;
  assign sie.phase_timer = timer_q;
  assign sie.sie_active  = active_q;
  assign sie.ignite_ack  = ack_q;
  assign sie.event_done  = done_q;
  assign sie.event_count = count_q;

`ifdef SIE_ENVELOPE_EN
  localparam logic signed [WIDTH:0] ENV_FULL = (WIDTH+1)'(1 << FRAC);
  localparam logic signed [WIDTH:0] ENV_QTR  = (WIDTH+1)'((1 << FRAC) / 4);
  localparam logic signed [WIDTH:0] ENV_3QTR = (WIDTH+1)'((3 * (1 << FRAC)) / 4);
  localparam logic signed [WIDTH:0] ENV_INC  = (WIDTH+1)'(ENV_STEP);

  logic signed [WIDTH-1:0] env_q, env_d;
  logic signed [WIDTH:0]   env_up, env_dn;

  // Envelope follows the post-update state; abort reaches REFR and so reads 0.
  always_comb begin
    env_up = {env_q[WIDTH-1], env_q} + ENV_INC;
    env_dn = {env_q[WIDTH-1], env_q} - ENV_INC;
    env_d  = env_q;
    if (clk_en) begin
      case (state_d)
        S_P2:    env_d = ENV_QTR[WIDTH-1:0];
        S_P3:    env_d = (env_up > ENV_FULL) ? ENV_FULL[WIDTH-1:0] : env_up[WIDTH-1:0];
        S_P4:    env_d = ENV_FULL[WIDTH-1:0];
        S_P5:    env_d = ENV_3QTR[WIDTH-1:0];
        S_P6:    env_d = env_dn[WIDTH] ? '0 : env_dn[WIDTH-1:0];
        default: env_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_q <= '0;
    end else begin
      env_q <= env_d;
    end
  end

  assign sie.envelope = env_q;
`else
  localparam int env_cfg_unused = WIDTH + FRAC + ENV_STEP;
  assign sie.envelope = '0;
`endif

endmodule

// File: tb/tb_sie_phase_sequencer.sv
// tb/tb_sie_phase_sequencer.sv - scoreboard bench for sie_phase_sequencer
module tb_sie_phase_sequencer;
  localparam int WIDTH = 18;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic clk_en = 1'b0;

  sie_phase_sequencer_if #(.WIDTH(WIDTH)) sie ();

  sie_phase_sequencer #(.WIDTH(WIDTH), .FRAC(14), .ENV_STEP(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .sie    (sie.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] phase;
    int         dwell;
    bit         ack;
    bit         done;
    logic [7:0] count;
    int         env;
  } rec_t;

  rec_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_acks = 0, exp_dones = 0, ack_seen = 0, done_seen = 0;
  logic [7:0] model_count = 8'd0;
  int         tick_div = 0;

  initial begin
    forever begin
      @(negedge clk);
      tick_div = (tick_div + 1) % 4;
      clk_en = (tick_div == 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int deff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int env_end(input int ph, input int d);
`ifdef SIE_ENVELOPE_EN
    int v;
    case (ph)
      2: v = 4096;
      3: begin v = 4096 + 2 * deff(d); if (v > 16384) v = 16384; end
      4: v = 16384;
      5: v = 12288;
      6: begin v = 12288 - 2 * deff(d); if (v < 0) v = 0; end
      default: v = 0;
    endcase
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic push_rec(input int ph, input int dwell, input bit ack, input bit done, input int env);
    rec_t r;
    r.phase = ph[2:0];
    r.dwell = dwell;
    r.ack   = ack;
    r.done  = done;
    r.count = model_count;
    r.env   = env;
    exp_q.push_back(r);
    if (ack) exp_acks++;
    if (done) exp_dones++;
  endtask

  task automatic push_event(input int d2, input int d3, input int d4, input int d5,
                            input int d6, input int dr, input int idle_dwell);
    model_count = model_count + 8'd1;
    push_rec(2, deff(d2), 1'b1, 1'b0, env_end(2, d2));
    push_rec(3, deff(d3), 1'b0, 1'b0, env_end(3, d3));
    push_rec(4, deff(d4), 1'b0, 1'b0, env_end(4, d4));
    push_rec(5, deff(d5), 1'b0, 1'b0, env_end(5, d5));
    push_rec(6, deff(d6), 1'b0, 1'b0, env_end(6, d6));
    push_rec(7, deff(dr), 1'b0, 1'b1, 0);
    push_rec(0, idle_dwell, 1'b0, 1'b0, 0);
  endtask

  task automatic set_durs(input int d2, input int d3, input int d4, input int d5,
                          input int d6, input int dr);
    sie.sie_phase2_dur = d2[15:0];
    sie.sie_phase3_dur = d3[15:0];
    sie.sie_phase4_dur = d4[15:0];
    sie.sie_phase5_dur = d5[15:0];
    sie.sie_phase6_dur = d6[15:0];
    sie.sie_refractory = dr[15:0];
  endtask

  task automatic wait_phase(input int ph, input int max_clks);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sie.phase !== ph[2:0] && n < max_clks);
    if (sie.phase !== ph[2:0]) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: got %0d expected %0d within %0d clks", sie.phase, ph, max_clks);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!clk_en);
    end
    @(negedge clk);
  endtask

  task automatic start_event();
    sie.ignite_req = 1'b1;
    wait_phase(2, 64);
    sie.ignite_req = 1'b0;
  endtask

  // Monitor: pops one expected record per observed phase change
  initial begin
    rec_t       cur;
    logic [2:0] cur_phase;
    int         dwell, prev_env;
    bit         tk;
    cur.phase = 3'd0; cur.dwell = 0; cur.ack = 1'b0; cur.done = 1'b0;
    cur.count = 8'd0; cur.env = 0;
    wait (rst === 1'b0);
    @(negedge clk);
    cur_phase = sie.phase;
    prev_env  = sie.envelope;
    dwell     = 0;
    forever begin
      @(posedge clk);
      tk = clk_en && !rst;
      @(negedge clk);
      if (sie.phase !== cur_phase) begin
        if (cur.dwell != 0) chk("dwell", dwell, cur.dwell);
        chk("env_end", prev_env, cur.env);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_phase: got %0d expected no change", sie.phase);
        end else begin
          cur = exp_q.pop_front();
          chk("phase", sie.phase, cur.phase);
          chk("ignite_ack", sie.ignite_ack, cur.ack);
          chk("event_done", sie.event_done, cur.done);
          chk("event_count", sie.event_count, cur.count);
        end
        cur_phase = sie.phase;
        dwell = tk ? 1 : 0;
        if (sie.phase != 3'd0) chk("timer_entry", sie.phase_timer, 0);
      end else begin
        if (sie.ignite_ack || sie.event_done) begin
          checks++;
          errors++;
          $display("FAIL stray_pulse: got ack=%0d done=%0d expected 0", sie.ignite_ack, sie.event_done);
        end
        if (tk) begin
          dwell++;
          if (cur_phase != 3'd0) chk("timer", sie.phase_timer, dwell - 1);
        end
      end
      chk("sie_active", sie.sie_active, (cur.phase >= 3'd2 && cur.phase <= 3'd6));
      if (sie.ignite_ack) ack_seen++;
      if (sie.event_done) done_seen++;
      prev_env = sie.envelope;
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_phase"}, sie.phase, 0);
    chk({tag, "_timer"}, sie.phase_timer, 0);
    chk({tag, "_active"}, sie.sie_active, 0);
    chk({tag, "_ack"}, sie.ignite_ack, 0);
    chk({tag, "_done"}, sie.event_done, 0);
    chk({tag, "_count"}, sie.event_count, 0);
    chk({tag, "_env"}, sie.envelope, 0);
  endtask

  initial begin
    sie.ignite_req = 1'b0;
    sie.abort      = 1'b0;
    set_durs(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_reset_values("por");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic sequence
    set_durs(2, 3, 1, 4, 2, 5);
    push_event(2, 3, 1, 4, 2, 5, 0);
    start_event();
    wait_phase(7, 400);
    wait_phase(0, 200);
    chk("basic_count", sie.event_count, 1);

    // Config stability: inputs change to 9 during P3
    push_event(2, 3, 1, 4, 2, 5, 0);
    start_event();
    wait_phase(3, 64);
    set_durs(9, 9, 9, 9, 9, 9);
    wait_phase(0, 1000);
    push_event(9, 9, 9, 9, 9, 9, 0);
    start_event();
    wait_phase(0, 2000);

    // Abort at P4 tick 0 with ignite_req held through REFR
    set_durs(2, 3, 1, 4, 2, 5);
    model_count = model_count + 8'd1;
    push_rec(2, 2, 1'b1, 1'b0, env_end(2, 2));
    push_rec(3, 3, 1'b0, 1'b0, env_end(3, 3));
    push_rec(4, 1, 1'b0, 1'b0, env_end(4, 1));
    push_rec(7, 5, 1'b0, 1'b0, 0);
    push_rec(0, 1, 1'b0, 1'b0, 0);
    push_event(2, 3, 1, 4, 2, 5, 0);
    sie.ignite_req = 1'b1;
    wait_phase(4, 200);
    sie.abort = 1'b1;
    wait_ticks(1);
    sie.abort = 1'b0;
    chk("abort_phase", sie.phase, 7);
    wait_phase(0, 200);
    wait_phase(2, 64);
    sie.ignite_req = 1'b0;
    wait_phase(0, 1000);

    // All durations zero
    set_durs(0, 0, 0, 0, 0, 0);
    push_event(0, 0, 0, 0, 0, 0, 0);
    start_event();
    wait_phase(0, 200);

    // Long P3 for the envelope ramp
    set_durs(1, 10, 1, 1, 2, 1);
    push_event(1, 10, 1, 1, 2, 1, 0);
    start_event();
    wait_phase(0, 400);

    // ignite_req together with abort in IDLE must not start
    sie.ignite_req = 1'b1;
    sie.abort      = 1'b1;
    wait_ticks(3);
    sie.ignite_req = 1'b0;
    sie.abort      = 1'b0;
    chk("req_abort_phase", sie.phase, 0);
    chk("req_abort_count", sie.event_count, int'(model_count));

    // Reset asserted mid-P5
    set_durs(2, 3, 1, 4, 2, 5);
    model_count = model_count + 8'd1;
    push_rec(2, 2, 1'b1, 1'b0, env_end(2, 2));
    push_rec(3, 3, 1'b0, 1'b0, env_end(3, 3));
    push_rec(4, 1, 1'b0, 1'b0, env_end(4, 1));
    push_rec(5, 0, 1'b0, 1'b0, env_end(5, 4));
    model_count = 8'd0;
    push_rec(0, 0, 1'b0, 1'b0, 0);
    start_event();
    wait_phase(5, 200);
    wait_ticks(2);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;

    // 256 back-to-back events: event_count wraps to 0
    set_durs(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) push_event(0, 0, 0, 0, 0, 0, (i == 255) ? 0 : 1);
    sie.ignite_req = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_phase(2, 64);
      if (i == 255) sie.ignite_req = 1'b0;
      wait_phase(7, 64);
    end
    wait_phase(0, 64);
    chk("count_wrap", sie.event_count, 0);

    repeat (8) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("ack_pulses", ack_seen, exp_acks);
    chk("done_pulses", done_seen, exp_dones);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
